// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC register plus DEPTH-entry first-word-fall-through prefetch queue between instruction ROM and decode.
module if_fetch_queue #(
  parameter int ADDR_W = 8,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter int PC_STEP = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_en_i,
  output logic [ADDR_W-1:0]          imem_addr_o,
  input  logic [INSTR_W-1:0]         imem_data_i,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  input  logic                       id_ready_i,
  output logic                       id_valid_o,
  output logic [INSTR_W-1:0]         id_instr_o,
  output logic [ADDR_W-1:0]          id_pc_o,
  output logic [ADDR_W-1:0]          id_next_pc_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [ADDR_W-1:0] npc_mem [DEPTH];
  logic [INSTR_W-1:0] ins_mem [DEPTH];
  logic push, pop;
  assign pc_inc = pc_q + STEP;
  assign imem_addr_o = pc_q;
  assign count_o = cnt_q;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign id_valid_o = !empty_o;
  // Redirect masks both handshakes so the flush cycle neither consumes nor fetches.
  assign pop = id_valid_o & id_ready_i & !redirect_i;
  assign push = fetch_en_i & !redirect_i & (!full_o | pop);
  assign id_instr_o = empty_o ? '0 : ins_mem[rd_q];
  assign id_pc_o = empty_o ? '0 : pc_mem[rd_q];
  assign id_next_pc_o = empty_o ? '0 : npc_mem[rd_q];
  always_comb begin
    pc_d = redirect_i ? redirect_pc_i : push ? pc_inc : pc_q;
    rd_d = redirect_i ? '0 : rd_q + PW'(pop);
    wr_d = redirect_i ? '0 : wr_q + PW'(push);
    cnt_d = redirect_i ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  // Storage is deliberately unreset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q] <= pc_q;
      npc_mem[wr_q] <= pc_inc;
      ins_mem[wr_q] <= imem_data_i;
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_if_fetch_queue;
  localparam int D = 4;
  logic clk = 0, rst_n = 0, fetch_en = 0, redirect = 0, id_ready = 0;
  logic [7:0] redirect_pc = 0, imem_addr, id_pc, id_next_pc;
  logic [31:0] imem_data, id_instr;
  logic [2:0] count;
  logic id_valid, full, empty;
  int n_vec = 0, n_err = 0;
  logic [7:0] m_pc;
  logic [7:0] m_q[$];

  if_fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en), .imem_addr_o(imem_addr),
    .imem_data_i(imem_data), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .id_ready_i(id_ready), .id_valid_o(id_valid), .id_instr_o(id_instr),
    .id_pc_o(id_pc), .id_next_pc_o(id_next_pc), .count_o(count),
    .full_o(full), .empty_o(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [7:0] a);
    return 32'h100 + 32'(a);
  endfunction

  assign imem_data = rom(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    logic [7:0] h;
    n = m_q.size();
    h = n != 0 ? m_q[0] : 8'h00;
    check("imem_addr", 32'(imem_addr), 32'(m_pc));
    check("count", 32'(count), n);
    check("full", 32'(full), 32'(n == D));
    check("empty", 32'(empty), 32'(n == 0));
    check("id_valid", 32'(id_valid), 32'(n != 0));
    check("id_pc", 32'(id_pc), 32'(h));
    check("id_next_pc", 32'(id_next_pc), n != 0 ? 32'(8'(h + 8'd4)) : 32'h0);
    check("id_instr", id_instr, n != 0 ? rom(h) : 32'h0);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc = 8'h00;
  endtask

  task automatic step(input logic fe, input logic rdy, input logic rd, input logic [7:0] rpc);
    bit pop, push;
    fetch_en = fe;
    id_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
    @(posedge clk);
    if (rd) begin
      m_q.delete();
      m_pc = rpc;
    end else begin
      pop = m_q.size() != 0 && rdy;
      push = fe && (m_q.size() < D || pop);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 8'd4;
      end
    end
    #1 check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    rst_n = 1;
    // fill from reset with decode stalled
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      check("t1_count", 32'(count), i + 1);
    end
    check("t1_full", 32'(full), 1);
    step(1, 0, 0, 0);
    check("t1_pc_hold", 32'(imem_addr), 32'h10);
    // streaming through a full queue
    for (int i = 0; i < 8; i++) begin
      check("t2_id_pc", 32'(id_pc), 32'(i * 4));
      check("t2_id_instr", id_instr, rom(8'(i * 4)));
      step(1, 1, 0, 0);
      check("t2_count", 32'(count), 4);
    end
    // drain
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    check("t3_empty", 32'(empty), 1);
    check("t3_instr", id_instr, 0);
    check("t3_pc", 32'(imem_addr), 32'h30);
    // redirect with three entries held and decode ready
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    check("t4_pre_count", 32'(count), 3);
    step(1, 1, 1, 8'h40);
    check("t4_count", 32'(count), 0);
    step(1, 0, 0, 0);
    check("t4_id_pc", 32'(id_pc), 32'h40);
    check("t4_id_next_pc", 32'(id_next_pc), 32'h44);
    // PC wrap at top of address space
    step(0, 0, 1, 8'hFC);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("t5_id_pc", 32'(id_pc), 32'hFC);
    check("t5_id_next_pc", 32'(id_next_pc), 32'h00);
    step(0, 1, 0, 0);
    check("t5_id_pc2", 32'(id_pc), 32'h00);
    // asynchronous reset mid-cycle
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    #2 rst_n = 0;
    #1 model_reset();
    check_all();
    check("t6_imem_addr", 32'(imem_addr), 32'h00);
    @(posedge clk);
    #1 rst_n = 1;
    step(1, 0, 0, 0);
    check("t6_first_pc", 32'(id_pc), 32'h00);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
           8'($urandom) & 8'hFC);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
